sw_input_handshake: RTL
=======================

Name: sw_input_handshake

Overview:
Upstream input stage between the board switches and the picoMIPS core. It synchronises and debounces the SW8 handshake switch and synchronises the SW[7:0] data switches. On each accepted SW8 press it latches one 8-bit operand and presents it to the core over a valid/ready handshake. A 1-bit operand index tells the core whether the current operand is X (first) or Y (second) of a coordinate pair.

Parameters:
DATA_W, 8, width of switch data / operand
SYNC_STAGES, 2, flip-flop synchroniser depth for sw_data and sw_hs (min 2)
DEBOUNCE_CYCLES, 3, consecutive identical synchronised samples required to change debounced SW8 level (min 1)

Ports:
fastclk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset (top level ties SW[9])
sw_data  input  DATA_W  raw SW[7:0], asynchronous
sw_hs  input  1  raw SW8 handshake switch, asynchronous
op_data  output  DATA_W  latched operand
op_valid  output  1  operand available to core
op_ready  input  1  core accepts operand this cycle
op_idx  output  1  0 = X operand, 1 = Y operand
hs_level  output  1  debounced SW8 level, for LED/debug
overrun  output  1  sticky: a press was lost while an operand was pending

Behaviour:
- Reset (reset_n low, async): all synchroniser flops 0, debounce counter 0, hs_level 0, FSM IDLE, op_data 0, op_valid 0, op_idx 0, overrun 0. Reset mid-operation discards any pending operand.
- Synchroniser: sw_data and sw_hs each pass through SYNC_STAGES flops.
- Debounce: counter increments while the synchronised sw_hs differs from hs_level. It clears when they match. When the count reaches DEBOUNCE_CYCLES, hs_level takes the new value and the counter clears. A glitch shorter than DEBOUNCE_CYCLES samples never changes hs_level.
- Rise event: hs_level 0->1. On the same edge that hs_level rises, the synchronised sw_data is captured into op_data.
- Latency: SW8 first sampled high at edge 0 -> op_valid high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. This is 6 edges (12 ns) with defaults.
- FSM:
  - IDLE: op_valid 0. On rise event, capture data, set op_valid=1 and go to PENDING.
  - PENDING: op_valid 1 and op_data held stable. When op_valid && op_ready: drop op_valid, toggle op_idx, and go to RELEASE if hs_level=1, else IDLE.
    - A further rise event in PENDING (switch released and re-pressed before acceptance) sets overrun. The old op_data is kept and the new data is dropped.
  - RELEASE: wait for hs_level=0, then go to IDLE. A press is accepted only once per high level.
- Simultaneous accept and rise event in PENDING: the accept completes, the FSM goes to RELEASE (hs_level=1), and overrun is set because the new press is dropped.
- op_ready is ignored when op_valid=0.
- op_idx wraps 1->0 after each Y accept. It changes only on accepts.
- overrun clears only on reset.

Optional Feature:
Macro SW_DEBOUNCE_EN.
- Defined: debounce counter as above.
- Undefined: no counter and no DEBOUNCE_CYCLES delay; hs_level equals the synchronised sw_hs. Latency becomes SYNC_STAGES+1 edges (3 with defaults). All FSM, overrun and op_idx rules are unchanged.

Test Plan:
1. Reset held 10 ns then released, sw_hs=0 -> all outputs 0; no op_valid for 100 ns.
2. sw_data=40, sw_hs high 10 ns, op_ready=1 -> op_valid pulses 1 cycle at edge 6 after first high sample, op_data=40, op_idx=0 during valid, then 1.
3. Repeat the press with sw_data=40 (X=40, Y=40 sequence twice) -> four operands with op_idx 0,1,0,1, all op_data=40, overrun 0.
4. sw_hs glitch high for 2 cycles -> hs_level stays 0, no op_valid. With SW_DEBOUNCE_EN undefined -> op_valid asserts at edge 3.
5. op_ready=0, press (data=5), release, press again (data=251) -> op_valid held with op_data=5, overrun=1. Then op_ready=1 -> op_data=5 accepted, overrun stays 1.
6. reset_n pulled low while PENDING -> op_valid, op_idx and overrun go 0 immediately (asynchronously).

Source files
------------

// File: rtl/sw_input_handshake.sv
// SW8/SW[7:0] input stage for the picoMIPS core: synchronise, debounce, latch one operand per press.
// Optional: define SW_DEBOUNCE_EN to debounce SW8; otherwise hs_level follows the synchronised SW8.
`timescale 1ns/100ps
module sw_input_handshake #(
   parameter int DATA_W          = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic              fastclk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              sw_hs,
   output logic [DATA_W-1:0] op_data,
   output logic              op_valid,
   input  logic              op_ready,
   output logic              op_idx,
   output logic              hs_level,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, PENDING, RELEASE} state_t;

   logic [SYNC_STAGES-1:0][DATA_W-1:0] dsync_q;
   logic [SYNC_STAGES-1:0]             hsync_q;
   logic [DATA_W-1:0]                  data_s;
   logic                               hs_s;

   always_ff @(posedge fastclk or negedge reset_n) begin
      if (!reset_n) begin
         dsync_q <= '0;
         hsync_q <= '0;
      end else begin
         dsync_q <= {dsync_q[SYNC_STAGES-2:0], sw_data};
         hsync_q <= {hsync_q[SYNC_STAGES-2:0], sw_hs};
      end
   end

   assign data_s = dsync_q[SYNC_STAGES-1];
   assign hs_s   = hsync_q[SYNC_STAGES-1];

   logic hs_level_q, hs_level_d, hs_prev_q;

`ifdef SW_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // Once DEBOUNCE_CYCLES differing samples have been counted the level flips,
   // whatever the sample on the flip cycle is.
   always_comb begin
      hs_level_d = hs_level_q;
      cnt_d      = '0;
      if (cnt_q == CW'(DEBOUNCE_CYCLES))
         hs_level_d = ~hs_level_q;
      else if (hs_s != hs_level_q)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge fastclk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   always_comb hs_level_d = hs_s;
`endif

   state_t            state_q, state_d;
   logic [DATA_W-1:0] cap_q, op_data_q, op_data_d;
   logic              idx_q, idx_d, ovr_q, ovr_d, rise;

   assign rise = hs_level_q & ~hs_prev_q;

   always_comb begin
      state_d   = state_q;
      op_data_d = op_data_q;
      idx_d     = idx_q;
      ovr_d     = ovr_q | (rise & (state_q == PENDING));
      case (state_q)
         IDLE: if (rise) begin
            state_d   = PENDING;
            op_data_d = cap_q;
         end
         PENDING: if (op_ready) begin
            idx_d   = ~idx_q;
            state_d = hs_level_q ? RELEASE : IDLE;
         end
         RELEASE: if (!hs_level_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cap_q grabs the data on the edge the level rises; it only reaches op_data from IDLE,
   // so a press landing while an operand is pending never disturbs op_data.
   always_ff @(posedge fastclk or negedge reset_n) begin
      if (!reset_n) begin
         hs_level_q <= 1'b0;
         hs_prev_q  <= 1'b0;
         cap_q      <= '0;
         state_q    <= IDLE;
         op_data_q  <= '0;
         idx_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         hs_level_q <= hs_level_d;
         hs_prev_q  <= hs_level_q;
         if (hs_level_d && !hs_level_q) cap_q <= data_s;
         state_q    <= state_d;
         op_data_q  <= op_data_d;
         idx_q      <= idx_d;
         ovr_q      <= ovr_d;
      end
   end

   assign op_data  = op_data_q;
   assign op_valid = (state_q == PENDING);
   assign op_idx   = idx_q;
   assign hs_level = hs_level_q;
   assign overrun  = ovr_q;

endmodule
